// File: rtl/ahb_cls_subordinate.sv
// ahb_cls_subordinate: AHB-Lite front end for the ASL classifier core.
// Decodes the register map and pixel windows, forwards pixel writes and start
// requests to the core, and latches completion/result for software polling.
module ahb_cls_subordinate #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          PIX_AW    = 10,
  parameter int          RES_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ahb_hsel_i,
  input  logic [31:0]       ahb_haddr_i,
  input  logic              ahb_hwrite_i,
  input  logic [2:0]        ahb_hsize_i,
  input  logic [1:0]        ahb_htrans_i,
  input  logic [31:0]       ahb_hwdata_i,
  input  logic              ahb_hready_i,
  output logic              ahb_hreadyout_o,
  output logic              ahb_hresp_o,
  output logic [31:0]       ahb_hrdata_o,
  output logic              pix_we_o,
  output logic [1:0]        pix_ch_o,
  output logic [PIX_AW-1:0] pix_addr_o,
  output logic [7:0]        pix_data_o,
  output logic              core_start_o,
  output logic [7:0]        core_dim_o,
  input  logic              core_done_i,
  input  logic [RES_W-1:0]  core_result_i
);

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;
  typedef enum logic [2:0] {R_CTRL, R_CFG, R_STATUS, R_RESULT, R_PIX, R_NONE} region_t;

  state_t              state, state_nxt;
  region_t             ap_region, dp_region;
  logic                accept, ap_err;
  logic                dp_vld, dp_write;
  logic [1:0]          dp_ch;
  logic [PIX_AW-1:0]   dp_addr;
  logic [7:0]          cfg_dim;
  logic                busy, done;
  logic [RES_W-1:0]    result;
  logic                start_acc, pix_acc, cfg_acc;
  logic [15:0]         off;
  logic                unused_ok;

  // hsize is decoded by the bus but irrelevant here; only byte 0 of hwdata matters
  assign unused_ok = &{1'b0, ahb_hsize_i, ahb_hwdata_i[31:8]};

  assign off    = ahb_haddr_i[15:0];
  assign accept = ahb_hsel_i & ahb_htrans_i[1] & ahb_hready_i;

  // Data-phase side effects, qualified by the registered address phase
  assign start_acc = dp_vld & dp_write & (dp_region == R_CTRL) & ahb_hwdata_i[0] & ~busy;
  assign pix_acc   = dp_vld & dp_write & (dp_region == R_PIX);
  assign cfg_acc   = dp_vld & dp_write & (dp_region == R_CFG);

  // Address-phase decode and error classification. A start being taken this
  // cycle counts as busy so a pixel write right behind it is rejected.
  always_comb begin
    ap_region = R_NONE;
    if (off == 16'h0000)                                    ap_region = R_CTRL;
    else if (off == 16'h0004)                               ap_region = R_CFG;
    else if (off == 16'h1000)                               ap_region = R_STATUS;
    else if (off == 16'h1004)                               ap_region = R_RESULT;
    else if (off[15:12] == 4'h2 && off[11:10] != 2'b11)     ap_region = R_PIX;
    ap_err = (ahb_haddr_i[31:16] != BASE_ADDR[31:16]) || (ap_region == R_NONE) ||
             (ahb_hwrite_i && (ap_region == R_STATUS || ap_region == R_RESULT)) ||
             (ahb_hwrite_i && ap_region == R_PIX && (busy || start_acc));
  end

  // Register the accepted address phase; rejected transfers never reach data phase
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_vld    <= 1'b0;
      dp_write  <= 1'b0;
      dp_region <= R_NONE;
      dp_ch     <= 2'd0;
      dp_addr   <= '0;
    end else begin
      dp_vld <= accept & ~ap_err;
      if (accept) begin
        dp_write  <= ahb_hwrite_i;
        dp_region <= ap_region;
        dp_ch     <= ahb_haddr_i[11:10];
        dp_addr   <= ahb_haddr_i[PIX_AW-1:0];
      end
    end
  end

  // Error FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Error FSM next state and two-cycle ERROR response outputs
  always_comb begin
    state_nxt       = state;
    ahb_hreadyout_o = 1'b1;
    ahb_hresp_o     = 1'b0;
    case (state)
      S_IDLE: if (accept && ap_err) state_nxt = S_ERR1;
      S_ERR1: begin
        ahb_hreadyout_o = 1'b0;
        ahb_hresp_o     = 1'b1;
        state_nxt       = S_ERR2;
      end
      S_ERR2: begin
        ahb_hresp_o = 1'b1;
        state_nxt   = (accept && ap_err) ? S_ERR1 : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control/status registers; an accepted start outranks a same-cycle completion
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_dim      <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      core_start_o <= 1'b0;
    end else begin
      core_start_o <= start_acc;
      if (cfg_acc) cfg_dim <= ahb_hwdata_i[7:0];
      if (core_done_i) result <= core_result_i;
      if (start_acc) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (core_done_i) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // Pixel write strobe one cycle after the data phase; payload held until next write
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_we_o   <= 1'b0;
      pix_ch_o   <= 2'd0;
      pix_addr_o <= '0;
      pix_data_o <= 8'd0;
    end else begin
      pix_we_o <= pix_acc;
      if (pix_acc) begin
        pix_ch_o   <= dp_ch;
        pix_addr_o <= dp_addr;
        pix_data_o <= ahb_hwdata_i[7:0];
      end
    end
  end

  // Read data mux; write-only locations read as zero
  always_comb begin
    ahb_hrdata_o = 32'd0;
    if (dp_vld && !dp_write) begin
      case (dp_region)
        R_CFG:    ahb_hrdata_o = {24'd0, cfg_dim};
        R_STATUS: ahb_hrdata_o = {30'd0, busy, done};
        R_RESULT: ahb_hrdata_o = 32'(result);
        default:  ahb_hrdata_o = 32'd0;
      endcase
    end
  end

  assign core_dim_o = cfg_dim;

endmodule

// File: tb/tb_ahb_cls_subordinate.sv
// tb_ahb_cls_subordinate: directed bench for the classifier AHB subordinate.
module tb_ahb_cls_subordinate;

  logic        clk, reset;
  logic        hsel, hwrite, hready, hreadyout, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        pix_we, core_start, core_done;
  logic [1:0]  pix_ch;
  logic [9:0]  pix_addr;
  logic [7:0]  pix_data, core_dim, core_result;

  int nvec = 0;
  int nerr = 0;
  int pix_cnt = 0;
  int start_cnt = 0;
  logic [1:0] log_ch   [0:4095];
  logic [9:0] log_addr [0:4095];
  logic [7:0] log_data [0:4095];

  logic [31:0] rd;
  logic        rf, rl;
  int          w;

  assign hready = hreadyout;

  ahb_cls_subordinate dut (
    .clk(clk), .reset(reset),
    .ahb_hsel_i(hsel), .ahb_haddr_i(haddr), .ahb_hwrite_i(hwrite), .ahb_hsize_i(hsize),
    .ahb_htrans_i(htrans), .ahb_hwdata_i(hwdata), .ahb_hready_i(hready),
    .ahb_hreadyout_o(hreadyout), .ahb_hresp_o(hresp), .ahb_hrdata_o(hrdata),
    .pix_we_o(pix_we), .pix_ch_o(pix_ch), .pix_addr_o(pix_addr), .pix_data_o(pix_data),
    .core_start_o(core_start), .core_dim_o(core_dim),
    .core_done_i(core_done), .core_result_i(core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every pixel strobe and count start pulses
  always @(posedge clk) begin
    if (pix_we) begin
      log_ch[pix_cnt]   <= pix_ch;
      log_addr[pix_cnt] <= pix_addr;
      log_data[pix_cnt] <= pix_data;
      pix_cnt           <= pix_cnt + 1;
    end
    if (core_start) start_cnt <= start_cnt + 1;
  end

  // Single transfer: address phase, then data phase until hreadyout (bounded)
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rdat, output logic rsp_first,
                      output logic rsp_last, output int waits);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
    waits = 0;
    rsp_first = hresp;
    while (hreadyout !== 1'b1 && waits < 8) begin
      waits++;
      @(posedge clk); #1;
    end
    rdat = hrdata;
    rsp_last = hresp;
    if (waits >= 8) begin
      nvec++; nerr++;
      $display("FAIL xfer_timeout addr=%h: hreadyout stuck low", addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_done(input logic [7:0] r);
    core_done = 1'b1; core_result = r;
    @(posedge clk); #1;
    core_done = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; hsel = 0; haddr = 0; hwrite = 0; hsize = 0; htrans = 0; hwdata = 0;
    core_done = 0; core_result = 0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    nvec++;
    if ({hreadyout, hresp, hrdata, pix_we, core_start, core_dim} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0}) begin
      nerr++;
      $display("FAIL reset_outputs: rdy=%b rsp=%b rd=%h we=%b st=%b dim=%h, want 1 0 0 0 0 0",
               hreadyout, hresp, hrdata, pix_we, core_start, core_dim);
    end
    xfer(0, 32'h8000_1000, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'd0) begin nerr++; $display("FAIL reset_status: got %h want 0", rd); end
    xfer(0, 32'h8000_1004, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'd0) begin nerr++; $display("FAIL reset_result: got %h want 0", rd); end
  endtask

  task automatic test_cfg_rw;
    xfer(1, 32'h8000_0004, 32'd32, rd, rf, rl, w);
    nvec++;
    if ({rl, w} !== {1'b0, 32'd0}) begin nerr++; $display("FAIL cfg_write_resp: resp=%b waits=%0d want 0 0", rl, w); end
    xfer(0, 32'h8000_0004, 0, rd, rf, rl, w);
    nvec++;
    if ({rd, rl, w} !== {32'h20, 1'b0, 32'd0}) begin
      nerr++; $display("FAIL cfg_read: rd=%h resp=%b waits=%0d want 20 0 0", rd, rl, w);
    end
    nvec++;
    if (core_dim !== 8'h20) begin nerr++; $display("FAIL core_dim: got %h want 20", core_dim); end
    xfer(0, 32'h8000_0000, 0, rd, rf, rl, w);
    nvec++;
    if ({rd, rl} !== {32'd0, 1'b0}) begin nerr++; $display("FAIL ctrl_read: rd=%h resp=%b want 0 0", rd, rl); end
    xfer(0, 32'h8000_2005, 0, rd, rf, rl, w);
    nvec++;
    if ({rd, rl} !== {32'd0, 1'b0}) begin nerr++; $display("FAIL pix_read: rd=%h resp=%b want 0 0", rd, rl); end
  endtask

  task automatic test_pixel_write;
    int p0;
    p0 = pix_cnt;
    xfer(1, 32'h8000_2005, 32'h1234_56A5, rd, rf, rl, w);
    nvec++;
    if ({pix_we, pix_ch, pix_addr, pix_data} !== {1'b1, 2'd0, 10'd5, 8'hA5}) begin
      nerr++; $display("FAIL pix_ch0: we=%b ch=%0d addr=%h data=%h want 1 0 005 a5", pix_we, pix_ch, pix_addr, pix_data);
    end
    @(posedge clk); #1;
    nvec++;
    if ({pix_we, pix_data} !== {1'b0, 8'hA5}) begin
      nerr++; $display("FAIL pix_hold: we=%b data=%h want 0 a5", pix_we, pix_data);
    end
    xfer(1, 32'h8000_2805, 32'h0000_003C, rd, rf, rl, w);
    nvec++;
    if ({pix_we, pix_ch, pix_addr, pix_data} !== {1'b1, 2'd2, 10'd5, 8'h3C}) begin
      nerr++; $display("FAIL pix_ch2: we=%b ch=%0d addr=%h data=%h want 1 2 005 3c", pix_we, pix_ch, pix_addr, pix_data);
    end
    xfer(1, 32'h8000_27FF, 32'hFFFF_FF5A, rd, rf, rl, w);
    nvec++;
    if ({pix_we, pix_ch, pix_addr, pix_data} !== {1'b1, 2'd1, 10'h3FF, 8'h5A}) begin
      nerr++; $display("FAIL pix_edge: we=%b ch=%0d addr=%h data=%h want 1 1 3ff 5a", pix_we, pix_ch, pix_addr, pix_data);
    end
    @(posedge clk); #1;
    nvec++;
    if (pix_cnt - p0 !== 3) begin nerr++; $display("FAIL pix_count: got %0d want 3", pix_cnt - p0); end
  endtask

  task automatic test_start_done;
    int s0;
    s0 = start_cnt;
    xfer(1, 32'h8000_0000, 32'd1, rd, rf, rl, w);
    nvec++;
    if (core_start !== 1'b1) begin nerr++; $display("FAIL start_pulse: got %b want 1", core_start); end
    xfer(0, 32'h8000_1000, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h2) begin nerr++; $display("FAIL status_busy: got %h want 2", rd); end
    xfer(1, 32'h8000_0000, 32'd1, rd, rf, rl, w);
    nvec++;
    if ({core_start, rl, w} !== {1'b0, 1'b0, 32'd0}) begin
      nerr++; $display("FAIL start_while_busy: st=%b resp=%b waits=%0d want 0 0 0", core_start, rl, w);
    end
    pulse_done(8'h17);
    xfer(0, 32'h8000_1000, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h1) begin nerr++; $display("FAIL status_done: got %h want 1", rd); end
    xfer(0, 32'h8000_1004, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h17) begin nerr++; $display("FAIL result: got %h want 17", rd); end
    nvec++;
    if (start_cnt - s0 !== 1) begin nerr++; $display("FAIL start_count: got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_errors;
    logic [31:0] ea [5] = '{32'h8000_2010, 32'h8000_1000, 32'h8000_3000, 32'h9000_0004, 32'h8000_2C00};
    logic        ew [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int p0;
    xfer(1, 32'h8000_0000, 32'd1, rd, rf, rl, w);
    @(posedge clk); #1;
    p0 = pix_cnt;
    for (int i = 0; i < 5; i++) begin
      xfer(ew[i], ea[i], 32'h0000_00EE, rd, rf, rl, w);
      nvec++;
      if ({rf, rl, w} !== {1'b1, 1'b1, 32'd1}) begin
        nerr++; $display("FAIL err_resp[%0d] addr=%h: first=%b last=%b waits=%0d want 1 1 1", i, ea[i], rf, rl, w);
      end
    end
    @(posedge clk); #1;
    nvec++;
    if (pix_cnt !== p0) begin nerr++; $display("FAIL err_no_pix: got %0d strobes want 0", pix_cnt - p0); end
    xfer(0, 32'h8000_1000, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h2) begin nerr++; $display("FAIL err_status_kept: got %h want 2", rd); end
    xfer(0, 32'h8000_0004, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h20) begin nerr++; $display("FAIL err_cfg_kept: got %h want 20", rd); end
    pulse_done(8'h42);
    xfer(0, 32'h8000_1004, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h42) begin nerr++; $display("FAIL err_result: got %h want 42", rd); end
  endtask

  task automatic test_err2_accept;
    hsel = 1; htrans = 2'b10; haddr = 32'h8000_1000; hwrite = 1;
    @(posedge clk); #1;
    hsel = 0; htrans = 0; hwrite = 0; hwdata = 0;
    nvec++;
    if ({hreadyout, hresp} !== 2'b01) begin nerr++; $display("FAIL err1_phase: rdy=%b rsp=%b want 0 1", hreadyout, hresp); end
    @(posedge clk); #1;
    nvec++;
    if ({hreadyout, hresp} !== 2'b11) begin nerr++; $display("FAIL err2_phase: rdy=%b rsp=%b want 1 1", hreadyout, hresp); end
    hsel = 1; htrans = 2'b10; haddr = 32'h8000_0004; hwrite = 1;
    @(posedge clk); #1;
    hsel = 0; htrans = 0; hwrite = 0; hwdata = 32'h55;
    nvec++;
    if ({hreadyout, hresp} !== 2'b10) begin nerr++; $display("FAIL err2_next_okay: rdy=%b rsp=%b want 1 0", hreadyout, hresp); end
    @(posedge clk); #1;
    xfer(0, 32'h8000_0004, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h55) begin nerr++; $display("FAIL err2_cfg: got %h want 55", rd); end
  endtask

  task automatic test_start_done_collide;
    hsel = 1; htrans = 2'b10; haddr = 32'h8000_0000; hwrite = 1;
    @(posedge clk); #1;
    hsel = 0; htrans = 0; hwrite = 0; hwdata = 32'd1;
    core_done = 1; core_result = 8'h99;
    @(posedge clk); #1;
    core_done = 0;
    nvec++;
    if (core_start !== 1'b1) begin nerr++; $display("FAIL collide_start: got %b want 1", core_start); end
    xfer(0, 32'h8000_1000, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h2) begin nerr++; $display("FAIL collide_status: got %h want 2", rd); end
    xfer(0, 32'h8000_1004, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h99) begin nerr++; $display("FAIL collide_result: got %h want 99", rd); end
    pulse_done(8'h01);
    xfer(0, 32'h8000_1000, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'h1) begin nerr++; $display("FAIL collide_clear: got %h want 1", rd); end
  endtask

  task automatic test_back_to_back;
    int base, stalls, bad;
    logic [7:0] ed;
    base = pix_cnt; stalls = 0; bad = 0;
    for (int i = 0; i <= 1024; i++) begin
      if (i < 1024) begin
        hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h8000_2400 + 32'(i);
      end else begin
        hsel = 0; htrans = 0; hwrite = 0;
      end
      if (i > 0) hwdata = 32'((i - 1) * 7 + 3) & 32'hFF;
      if (hreadyout !== 1'b1 || hresp !== 1'b0) stalls++;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (stalls !== 0) begin nerr++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
    nvec++;
    if (pix_cnt - base !== 1024) begin nerr++; $display("FAIL b2b_count: got %0d want 1024", pix_cnt - base); end
    for (int j = 0; j < 1024; j++) begin
      ed = 8'(j * 7 + 3);
      if ({log_ch[base + j], log_addr[base + j], log_data[base + j]} !== {2'd1, 10'(j), ed}) begin
        if (bad == 0) $display("FAIL b2b_entry[%0d]: ch=%0d addr=%h data=%h want 1 %h %h",
                               j, log_ch[base + j], log_addr[base + j], log_data[base + j], 10'(j), ed);
        bad++;
      end
    end
    nvec++;
    if (bad !== 0) begin nerr++; $display("FAIL b2b_order: %0d bad entries want 0", bad); end
  endtask

  task automatic test_reset_mid;
    int s0;
    s0 = start_cnt;
    hsel = 1; htrans = 2'b10; haddr = 32'h8000_0000; hwrite = 1;
    @(posedge clk); #1;
    hsel = 0; htrans = 0; hwrite = 0; hwdata = 32'd1; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    nvec++;
    if ({hreadyout, hresp, hrdata, pix_we, core_start, core_dim} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0}) begin
      nerr++;
      $display("FAIL reset_mid_outputs: rdy=%b rsp=%b rd=%h we=%b st=%b dim=%h, want 1 0 0 0 0 0",
               hreadyout, hresp, hrdata, pix_we, core_start, core_dim);
    end
    @(posedge clk); #1;
    nvec++;
    if (start_cnt !== s0) begin nerr++; $display("FAIL reset_mid_nostart: %0d pulses want 0", start_cnt - s0); end
    xfer(0, 32'h8000_1000, 0, rd, rf, rl, w);
    nvec++;
    if (rd !== 32'd0) begin nerr++; $display("FAIL reset_mid_status: got %h want 0", rd); end
  endtask

  initial begin
    test_reset;
    test_cfg_rw;
    test_pixel_write;
    test_start_done;
    test_errors;
    test_err2_accept;
    test_start_done_collide;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
